// File: rtl/comb_gates_pkg.sv
// Shared types and sizing for the pairwise-gates decoder.
package comb_gates_pkg;

  localparam int unsigned NBITS = 4;

  // Width of a bit index able to address positions 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDX_W = idx_width(NBITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/comb_gates_4b_pairwise_decoder_if.sv
// Request/response bundle for the pairwise-gates decoder.
interface comb_gates_4b_pairwise_decoder_if
  import comb_gates_pkg::*;
#(
  parameter int unsigned nbits = NBITS
);

  logic             in_val;
  logic             in_rdy;
  logic             in_anchor;
  logic [nbits-2:0] in_and;
  logic [nbits-2:0] in_or;
  logic [nbits-2:0] in_xnor;
  logic             out_val;
  logic             out_rdy;
  logic [nbits-1:0] out_data;
  logic             out_err;

  modport master (
    output in_val, in_anchor, in_and, in_or, in_xnor, out_rdy,
    input  in_rdy, out_val, out_data, out_err
  );

  modport slave (
    input  in_val, in_anchor, in_and, in_or, in_xnor, out_rdy,
    output in_rdy, out_val, out_data, out_err
  );

endinterface

// File: rtl/comb_gates_pair_check.sv
// Flags a pair whose AND/OR summary disagrees with the rebuilt bits.
module comb_gates_pair_check (
  input  logic prev_bit,
  input  logic new_bit,
  input  logic and_bit,
  input  logic or_bit,
  output logic mismatch
);

  assign mismatch = (and_bit != (prev_bit & new_bit)) |
                    (or_bit  != (prev_bit | new_bit));

endmodule

// File: rtl/comb_gates_4b_pairwise_decoder.sv
// Rebuilds a vector from its pairwise AND/OR/XNOR summaries, one bit per cycle,
// and flags any AND/OR summary that contradicts the XNOR-derived data.
module comb_gates_4b_pairwise_decoder
  import comb_gates_pkg::*;
#(
  parameter int unsigned nbits = NBITS
) (
  input logic                            clk,
  input logic                            reset,
  comb_gates_4b_pairwise_decoder_if.slave bus
);

  localparam int unsigned pw    = nbits - 1;
  localparam int unsigned idx_w = (nbits == NBITS) ? IDX_W : idx_width(nbits);

  state_t             state_q, state_d;
  logic [idx_w-1:0]   idx_q, idx_d;
  logic [nbits-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic [pw-1:0]      and_q, and_d;
  logic [pw-1:0]      or_q, or_d;
  logic [pw-1:0]      xnor_q, xnor_d;
  logic               rdy_q, rdy_d;
  logic               val_q, val_d;

  logic [idx_w-1:0]   prev_idx;
  logic               prev_bit;
  logic               new_bit;
  logic               mismatch;

  // XNOR chain is authoritative: each new bit follows from its lower neighbour.
  assign prev_idx = idx_q - idx_w'(1);
  assign prev_bit = data_q[prev_idx];
  assign new_bit  = ~(prev_bit ^ xnor_q[prev_idx]);

  comb_gates_pair_check u_pair_check (
    .prev_bit (prev_bit),
    .new_bit  (new_bit),
    .and_bit  (and_q[prev_idx]),
    .or_bit   (or_q[prev_idx]),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      and_q   <= '0;
      or_q    <= '0;
      xnor_q  <= '0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      and_q   <= and_d;
      or_q    <= or_d;
      xnor_q  <= xnor_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    and_d   = and_q;
    or_d    = or_q;
    xnor_d  = xnor_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_val && rdy_q) begin
          and_d   = bus.in_and;
          or_d    = bus.in_or;
          xnor_d  = bus.in_xnor;
          data_d  = {{(nbits-1){1'b0}}, bus.in_anchor};
          err_d   = 1'b0;
          idx_d   = idx_w'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        data_d[idx_q] = new_bit;
        if (mismatch) err_d = 1'b1;
        idx_d = idx_q + idx_w'(1);
        if (idx_q == idx_w'(nbits - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags track the state being entered so they stay registered.
    rdy_d = (state_d == IDLE);
    val_d = (state_d == DONE);
  end

  assign bus.in_rdy   = rdy_q;
  assign bus.out_val  = val_q;
  assign bus.out_data = data_q;
  assign bus.out_err  = err_q;

endmodule

// File: tb/tb_comb_gates_4b_pairwise_decoder.sv
// Directed self-checking bench for the 4-bit pairwise-gates decoder.
module tb_comb_gates_4b_pairwise_decoder;

  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  comb_gates_4b_pairwise_decoder_if #(.nbits(NB)) bus ();

  comb_gates_4b_pairwise_decoder #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Drive one request; returns on the falling edge after the accept edge,
  // with the payload scrambled to show it is sampled only at accept.
  task automatic start_txn(input logic anc, input logic [2:0] x, input logic [2:0] a,
                           input logic [2:0] o);
    int k = 0;
    while (bus.in_rdy !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: in_rdy=%b required 1", bus.in_rdy);
    end
    bus.in_val    = 1'b1;
    bus.in_anchor = anc;
    bus.in_xnor   = x;
    bus.in_and    = a;
    bus.in_or     = o;
    @(negedge clk);
    bus.in_val    = 1'b0;
    bus.in_anchor = ~anc;
    bus.in_xnor   = ~x;
    bus.in_and    = 3'($urandom);
    bus.in_or     = 3'($urandom);
  endtask

  // Cycles from the accept edge until out_val is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (bus.out_val !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_val    = 1'b0;
    bus.in_anchor = 1'b0;
    bus.in_and    = '0;
    bus.in_or     = '0;
    bus.in_xnor   = '0;
    bus.out_rdy   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy_low: in_rdy=%b required 0", bus.in_rdy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL idle_rdy: in_rdy=%b required 1", bus.in_rdy);
    end
    n_checks++;
    if (bus.out_val !== 1'b0) begin
      n_fail++; $display("FAIL idle_val: out_val=%b required 0", bus.out_val);
    end
    n_checks++;
    if (bus.out_data !== 4'b0000) begin
      n_fail++; $display("FAIL idle_data: out_data=%b required 0000", bus.out_data);
    end
    n_checks++;
    if (bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL idle_err: out_err=%b required 0", bus.out_err);
    end
  endtask

  task automatic test_decode(input string name, input logic anc, input logic [2:0] x,
                             input logic [2:0] a, input logic [2:0] o,
                             input logic [3:0] exp_data, input logic exp_err);
    int lat;
    start_txn(anc, x, a, o);
    wait_result(lat);
    n_checks++;
    if (lat != 3) begin
      n_fail++; $display("FAIL %s_latency: cycles=%0d required 3", name, lat);
    end
    n_checks++;
    if (bus.out_data !== exp_data) begin
      n_fail++; $display("FAIL %s_data: out_data=%b required %b", name, bus.out_data, exp_data);
    end
    n_checks++;
    if (bus.out_err !== exp_err) begin
      n_fail++; $display("FAIL %s_err: out_err=%b required %b", name, bus.out_err, exp_err);
    end
    n_checks++;
    if (bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_rdy: in_rdy=%b required 0", name, bus.in_rdy);
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    n_checks++;
    if (bus.out_val !== 1'b0 || bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handoff: out_val=%b in_rdy=%b required 0 1", name, bus.out_val, bus.in_rdy);
    end
    n_checks++;
    if (bus.out_data !== exp_data) begin
      n_fail++; $display("FAIL %s_held: out_data=%b required %b", name, bus.out_data, exp_data);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_txn(1'b0, 3'b010, 3'b010, 3'b111);
    wait_result(lat);
    n_checks++;
    if (bus.out_val !== 1'b1) begin
      n_fail++; $display("FAIL bp_reach_done: out_val=%b required 1", bus.out_val);
    end
    for (int c = 0; c < 5; c++) begin
      bus.in_val    = 1'b1;
      bus.in_anchor = 1'b1;
      bus.in_xnor   = 3'b111;
      bus.in_and    = 3'b111;
      bus.in_or     = 3'b111;
      @(negedge clk);
      n_checks++;
      if (bus.out_val !== 1'b1 || bus.in_rdy !== 1'b0 || bus.out_data !== 4'b0110) begin
        n_fail++;
        $display("FAIL bp_stall%0d: out_val=%b in_rdy=%b out_data=%b required 1 0 0110",
                 c, bus.out_val, bus.in_rdy, bus.out_data);
      end
    end
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    n_checks++;
    if (bus.out_val !== 1'b0 || bus.in_rdy !== 1'b1 || bus.out_data !== 4'b0110) begin
      n_fail++;
      $display("FAIL bp_release: out_val=%b in_rdy=%b out_data=%b required 0 1 0110",
               bus.out_val, bus.in_rdy, bus.out_data);
    end
  endtask

  task automatic test_reset_mid_decode();
    start_txn(1'b1, 3'b111, 3'b111, 3'b111);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_val !== 1'b0 || bus.out_data !== 4'b0000 || bus.out_err !== 1'b0 ||
        bus.in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: out_val=%b out_data=%b out_err=%b in_rdy=%b required 0 0000 0 0",
               bus.out_val, bus.out_data, bus.out_err, bus.in_rdy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_rdy !== 1'b1 || bus.out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: in_rdy=%b out_val=%b required 1 0", bus.in_rdy, bus.out_val);
    end
    test_decode("after_reset", 1'b1, 3'b010, 3'b000, 3'b101, 4'b1001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode("basic", 1'b0, 3'b010, 3'b010, 3'b111, 4'b0110, 1'b0);
    test_decode("ones", 1'b1, 3'b111, 3'b111, 3'b111, 4'b1111, 1'b0);
    test_decode("zeros", 1'b0, 3'b111, 3'b000, 3'b000, 4'b0000, 1'b0);
    test_decode("and_err", 1'b0, 3'b111, 3'b001, 3'b000, 4'b0000, 1'b1);
    test_decode("or_err_top", 1'b1, 3'b010, 3'b000, 3'b001, 4'b1001, 1'b1);
    test_decode("err_clears", 1'b0, 3'b111, 3'b000, 3'b000, 4'b0000, 1'b0);
    test_backpressure();
    test_reset_mid_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
